// File: rtl/target_pkg.sv
// Shared definitions for the target lock controller: state encoding,
// default parameter values and a small sizing helper.
package target_pkg;

  localparam int COORD_W_DEF         = 12;
  localparam int LOCK_SAMPLES_DEF    = 8;
  localparam int AIM_TOL_DEF         = 4;
  localparam int LOST_TIMEOUT_DEF    = 1024;
  localparam int FIRE_CYCLES_DEF     = 16;
  localparam int COOLDOWN_CYCLES_DEF = 256;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ACQUIRE  = 3'd1,
    ST_TRACKING = 3'd2,
    ST_LOCKED   = 3'd3,
    ST_FIRING   = 3'd4,
    ST_COOLDOWN = 3'd5,
    ST_COAST    = 3'd6
  } state_e;

  function automatic int max3(int a, int b, int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/aim_stability_checker.sv
// Compares each hit against the previous hit and counts consecutive stable
// hits; locked_ok_o reflects the counter value after this cycle's update.
module aim_stability_checker
  import target_pkg::*;
#(
  parameter int COORD_W      = COORD_W_DEF,
  parameter int LOCK_SAMPLES = LOCK_SAMPLES_DEF,
  parameter int AIM_TOL      = AIM_TOL_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               hit_i,
  input  logic               flush_i,
  input  logic               clr_i,
  input  logic [COORD_W-1:0] x_i,
  input  logic [COORD_W-1:0] y_i,
  output logic               stable_hit_o,
  output logic               locked_ok_o
);

  localparam int                CNT_W  = $clog2(LOCK_SAMPLES + 1);
  localparam logic [CNT_W-1:0]  LOCK_N = CNT_W'(LOCK_SAMPLES);
  localparam logic [COORD_W:0]  TOL    = (COORD_W + 1)'(AIM_TOL);

  logic [COORD_W-1:0] prev_x_q, prev_y_q;
  logic               prev_valid_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [COORD_W:0]   dx, dy;

  // NOTE: every output of this block gets a value before any branch so no latch is inferred.
  always_comb begin
    dx = (x_i >= prev_x_q) ? ({1'b0, x_i} - {1'b0, prev_x_q}) : ({1'b0, prev_x_q} - {1'b0, x_i});
    dy = (y_i >= prev_y_q) ? ({1'b0, y_i} - {1'b0, prev_y_q}) : ({1'b0, prev_y_q} - {1'b0, y_i});
    stable_hit_o = hit_i && prev_valid_q && (dx <= TOL) && (dy <= TOL);
    cnt_d = cnt_q;
    if (hit_i) begin
      if (!stable_hit_o)        cnt_d = '0;
      else if (cnt_q != LOCK_N) cnt_d = cnt_q + 1'b1;
    end
    locked_ok_o = (cnt_d == LOCK_N);
  end

  // The first hit of an engagement only seeds the reference point.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_x_q     <= '0;
      prev_y_q     <= '0;
      prev_valid_q <= 1'b0;
      cnt_q        <= '0;
    end else if (flush_i) begin
      prev_valid_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      cnt_q <= clr_i ? '0 : cnt_d;
      if (hit_i) begin
        prev_x_q     <= x_i;
        prev_y_q     <= y_i;
        prev_valid_q <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/target_lock_fsm.sv
// Target acquisition, lock and fire sequencer driving servo aim coordinates
// and a laser fire pulse from tracker samples.
module target_lock_fsm
  import target_pkg::*;
#(
  parameter int                 COORD_W         = COORD_W_DEF,
  parameter int                 LOCK_SAMPLES    = LOCK_SAMPLES_DEF,
  parameter int                 AIM_TOL         = AIM_TOL_DEF,
  parameter int                 LOST_TIMEOUT    = LOST_TIMEOUT_DEF,
  parameter int                 FIRE_CYCLES     = FIRE_CYCLES_DEF,
  parameter int                 COOLDOWN_CYCLES = COOLDOWN_CYCLES_DEF,
  parameter logic [COORD_W-1:0] CENTER_X        = {1'b1, {(COORD_W-1){1'b0}}},
  parameter logic [COORD_W-1:0] CENTER_Y        = {1'b1, {(COORD_W-1){1'b0}}}
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               arm,
  input  logic               sample_valid,
  input  logic               on_screen,
  input  logic [COORD_W-1:0] tracked_x,
  input  logic [COORD_W-1:0] tracked_y,
  output logic [COORD_W-1:0] driven_x,
  output logic [COORD_W-1:0] driven_y,
  output logic               fire,
  output logic [2:0]         state,
  output logic [7:0]         shot_count
);

  localparam int               CNT_MAX   = max3(LOST_TIMEOUT, FIRE_CYCLES, COOLDOWN_CYCLES);
  localparam int               CNT_W     = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(LOST_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] FIRE_LAST = CNT_W'(FIRE_CYCLES - 1);
  localparam logic [CNT_W-1:0] COOL_LAST = CNT_W'(COOLDOWN_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'(CNT_MAX);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [COORD_W-1:0] driven_x_q, driven_y_q;
  logic               fire_q;
  logic [7:0]         shot_q;

  logic hit, miss, unstable_hit, tmo, stable_hit, locked_ok, flush, clr;

  assign hit          = sample_valid & on_screen;
  assign miss         = sample_valid & ~on_screen;
  assign unstable_hit = hit & ~stable_hit;
  assign tmo          = (cnt_q == TMO_LAST) & ~hit;
  assign flush        = (state_d == ST_IDLE);
  assign clr          = (state_d == ST_COAST) && (state_q != ST_COAST);

  aim_stability_checker #(
    .COORD_W      (COORD_W),
    .LOCK_SAMPLES (LOCK_SAMPLES),
    .AIM_TOL      (AIM_TOL)
  ) u_checker (
    .clk          (clk),
    .rst          (rst),
    .hit_i        (hit),
    .flush_i      (flush),
    .clr_i        (clr),
    .x_i          (tracked_x),
    .y_i          (tracked_y),
    .stable_hit_o (stable_hit),
    .locked_ok_o  (locked_ok)
  );

  always_comb begin
    state_d = state_q;
    if (!en) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:     if (hit) state_d = ST_ACQUIRE;
        ST_ACQUIRE:  if (hit) state_d = ST_TRACKING;
                     else if (miss || tmo) state_d = ST_COAST;
        ST_TRACKING: if (miss || tmo) state_d = ST_COAST;
                     else if (locked_ok) state_d = ST_LOCKED;
        ST_LOCKED:   if (unstable_hit) state_d = ST_TRACKING;
                     else if (miss || tmo) state_d = ST_COAST;
                     else if (arm) state_d = ST_FIRING;
        ST_FIRING:   if (!arm || cnt_q == FIRE_LAST) state_d = ST_COOLDOWN;
        ST_COOLDOWN: if (cnt_q == COOL_LAST) state_d = locked_ok ? ST_LOCKED : ST_TRACKING;
        ST_COAST:    if (hit) state_d = ST_TRACKING;
                     else if (tmo) state_d = ST_IDLE;
        default:     state_d = ST_IDLE;
      endcase
    end
  end

  // NOTE: all state here updates with <= so every register sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      driven_x_q <= CENTER_X;
      driven_y_q <= CENTER_Y;
      fire_q     <= 1'b0;
      shot_q     <= '0;
    end else begin
      state_q <= state_d;
      fire_q  <= (state_d == ST_FIRING);
      // One counter serves as timeout, pulse length and cooldown timer.
      if (state_d != state_q || state_q == ST_IDLE)
        cnt_q <= '0;
      else if (hit && state_q != ST_FIRING && state_q != ST_COOLDOWN)
        cnt_q <= '0;
      else if (cnt_q != CNT_SAT)
        cnt_q <= cnt_q + 1'b1;
      if (state_d == ST_FIRING && state_q != ST_FIRING && shot_q != 8'hFF)
        shot_q <= shot_q + 8'd1;
      if (state_d == ST_IDLE) begin
        driven_x_q <= CENTER_X;
        driven_y_q <= CENTER_Y;
      end else if (hit) begin
        driven_x_q <= tracked_x;
        driven_y_q <= tracked_y;
      end
    end
  end

  assign state      = state_q;
  assign driven_x   = driven_x_q;
  assign driven_y   = driven_y_q;
  assign fire       = fire_q;
  assign shot_count = shot_q;

endmodule

// File: tb/tb_target_lock_fsm.sv
// Scenario bench for target_lock_fsm: expected outputs are queued per cycle
// and compared by a negedge monitor, plus inline checks per scenario.
module tb_target_lock_fsm;
  import target_pkg::*;

  localparam int CX = 2048;

  logic        clk = 1'b0;
  logic        rst, en, arm, sample_valid, on_screen;
  logic [11:0] tracked_x, tracked_y, driven_x, driven_y;
  logic        fire;
  logic [2:0]  state;
  logic [7:0]  shot_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0]  st;
    logic [11:0] x;
    logic [11:0] y;
    logic        f;
    logic [7:0]  sh;
    string       tag;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;

  target_lock_fsm #(
    .COORD_W(12), .LOCK_SAMPLES(4), .AIM_TOL(2),
    .LOST_TIMEOUT(8), .FIRE_CYCLES(3), .COOLDOWN_CYCLES(5)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .arm(arm),
    .sample_valid(sample_valid), .on_screen(on_screen),
    .tracked_x(tracked_x), .tracked_y(tracked_y),
    .driven_x(driven_x), .driven_y(driven_y),
    .fire(fire), .state(state), .shot_count(shot_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      checks++;
      if (state !== mon_e.st || driven_x !== mon_e.x || driven_y !== mon_e.y ||
          fire !== mon_e.f || shot_count !== mon_e.sh) begin
        errors++;
        $display("FAIL %s: got st=%0d x=%0d y=%0d fire=%b shots=%0d, expected st=%0d x=%0d y=%0d fire=%b shots=%0d",
                 mon_e.tag, state, driven_x, driven_y, fire, shot_count,
                 mon_e.st, mon_e.x, mon_e.y, mon_e.f, mon_e.sh);
      end
    end
  end

  task automatic cyc(input logic a, input logic v, input logic o, input int tx, input int ty,
                     input state_e est, input int ex, input int ey, input logic ef,
                     input int esh, input string tag);
    exp_t e;
    arm = a; sample_valid = v; on_screen = o;
    tracked_x = 12'(tx); tracked_y = 12'(ty);
    @(posedge clk);
    e.st = est; e.x = 12'(ex); e.y = 12'(ey); e.f = ef; e.sh = 8'(esh); e.tag = tag;
    sb_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic hit_c(input logic a, input int tx, input int ty, input state_e est,
                       input int ex, input int ey, input logic ef, input int esh, input string tag);
    cyc(a, 1'b1, 1'b1, tx, ty, est, ex, ey, ef, esh, tag);
  endtask

  task automatic none_c(input logic a, input state_e est, input int ex, input int ey,
                        input logic ef, input int esh, input string tag);
    cyc(a, 1'b0, 1'b0, 0, 0, est, ex, ey, ef, esh, tag);
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; arm = 1'b0; sample_valid = 1'b0; on_screen = 1'b0;
    tracked_x = '0; tracked_y = '0;
    #3;
    checks++;
    if (state !== 3'(ST_IDLE) || driven_x !== 12'(CX) || driven_y !== 12'(CX) ||
        fire !== 1'b0 || shot_count !== 8'd0) begin
      errors++;
      $display("FAIL reset_state: got st=%0d x=%0d y=%0d fire=%b shots=%0d, expected st=0 x=2048 y=2048 fire=0 shots=0",
               state, driven_x, driven_y, fire, shot_count);
    end
    @(negedge clk); @(negedge clk);
    rst = 1'b0; en = 1'b1;
  endtask

  task automatic test_lock_fire();
    hit_c(1, 100, 200, ST_ACQUIRE,  100, 200, 0, 0, "lock_hit1");
    hit_c(1, 101, 201, ST_TRACKING, 101, 201, 0, 0, "lock_hit2");
    hit_c(1, 102, 200, ST_TRACKING, 102, 200, 0, 0, "lock_hit3");
    hit_c(1, 101, 199, ST_TRACKING, 101, 199, 0, 0, "lock_hit4");
    hit_c(1, 100, 200, ST_LOCKED,   100, 200, 0, 0, "lock_hit5");
    for (int i = 0; i < 3; i++) none_c(1, ST_FIRING, 100, 200, 1, 1, "fire_pulse");
    for (int i = 0; i < 5; i++) none_c(1, ST_COOLDOWN, 100, 200, 0, 1, "cooldown");
    none_c(0, ST_LOCKED, 100, 200, 0, 1, "relock_after_cooldown");
    none_c(0, ST_LOCKED, 100, 200, 0, 1, "locked_hold");
  endtask

  task automatic test_coast();
    cyc(0, 1, 0, 500, 500, ST_COAST, 100, 200, 0, 1, "miss_to_coast");
    for (int i = 0; i < 7; i++) none_c(0, ST_COAST, 100, 200, 0, 1, "coast_hold");
    none_c(0, ST_IDLE, CX, CX, 0, 1, "coast_timeout_idle");
  endtask

  task automatic test_unstable();
    hit_c(0, 100, 200, ST_ACQUIRE,  100, 200, 0, 1, "unst_acq");
    hit_c(0, 100, 200, ST_TRACKING, 100, 200, 0, 1, "unst_c1");
    hit_c(0, 101, 200, ST_TRACKING, 101, 200, 0, 1, "unst_c2");
    hit_c(0, 104, 200, ST_TRACKING, 104, 200, 0, 1, "unst_jump");
    for (int i = 0; i < 3; i++) hit_c(0, 104, 200, ST_TRACKING, 104, 200, 0, 1, "unst_recount");
    hit_c(0, 106, 202, ST_LOCKED, 106, 202, 0, 1, "tol_boundary_lock");
    hit_c(0, 110, 202, ST_TRACKING, 110, 202, 0, 1, "locked_unstable");
  endtask

  task automatic test_arm_drop();
    for (int i = 0; i < 3; i++) hit_c(0, 110, 202, ST_TRACKING, 110, 202, 0, 1, "relock_count");
    hit_c(0, 110, 202, ST_LOCKED, 110, 202, 0, 1, "relock");
    none_c(1, ST_FIRING, 110, 202, 1, 2, "drop_fire1");
    none_c(1, ST_FIRING, 110, 202, 1, 2, "drop_fire2");
    none_c(0, ST_COOLDOWN, 110, 202, 0, 2, "arm_drop_cooldown");
    cyc(0, 1, 0, 700, 700, ST_COOLDOWN, 110, 202, 0, 2, "cooldown_miss");
    none_c(0, ST_COOLDOWN, 110, 202, 0, 2, "cooldown_wait");
    hit_c(0, 120, 202, ST_COOLDOWN, 120, 202, 0, 2, "cooldown_unstable_hit");
    none_c(0, ST_COOLDOWN, 120, 202, 0, 2, "cooldown_wait2");
    none_c(0, ST_TRACKING, 120, 202, 0, 2, "cooldown_to_tracking");
  endtask

  task automatic test_saturation();
    int pulses = 0, gap = 0, len = 0, bad_len = 0, min_gap = 1000;
    logic prev_f = 1'b0;
    for (int i = 0; i < 3; i++) hit_c(0, 120, 202, ST_TRACKING, 120, 202, 0, 2, "sat_count");
    hit_c(0, 120, 202, ST_LOCKED, 120, 202, 0, 2, "sat_lock");
    arm = 1'b1; sample_valid = 1'b0; on_screen = 1'b0;
    for (int c = 0; c < 4000 && pulses < 256; c++) begin
      @(negedge clk);
      if (fire && !prev_f) begin
        pulses++;
        if (pulses > 1 && gap < min_gap) min_gap = gap;
        len = 0;
      end
      if (!fire && prev_f && len != 3) bad_len++;
      if (fire) begin len++; gap = 0; end else gap++;
      prev_f = fire;
    end
    checks++;
    if (pulses != 256) begin
      errors++;
      $display("FAIL sat_pulse_count: got %0d pulses, expected 256 within budget", pulses);
    end
    checks++;
    if (shot_count !== 8'd255) begin
      errors++;
      $display("FAIL shot_saturate: got %0d, expected 255", shot_count);
    end
    checks++;
    if (bad_len != 0) begin
      errors++;
      $display("FAIL pulse_width: got %0d pulses not 3 cycles long, expected 0", bad_len);
    end
    checks++;
    if (min_gap < 5) begin
      errors++;
      $display("FAIL cooldown_gap: got min gap %0d, expected at least 5", min_gap);
    end
  endtask

  task automatic test_reset_firing();
    checks++;
    if (fire !== 1'b1 || state !== 3'(ST_FIRING)) begin
      errors++;
      $display("FAIL pre_reset_firing: got st=%0d fire=%b, expected st=4 fire=1", state, fire);
    end
    #2; rst = 1'b1;
    #1;
    checks++;
    if (fire !== 1'b0 || state !== 3'(ST_IDLE) || driven_x !== 12'(CX) ||
        driven_y !== 12'(CX) || shot_count !== 8'd0) begin
      errors++;
      $display("FAIL async_reset: got st=%0d x=%0d y=%0d fire=%b shots=%0d, expected st=0 x=2048 y=2048 fire=0 shots=0",
               state, driven_x, driven_y, fire, shot_count);
    end
    arm = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_enable();
    hit_c(0, 300, 300, ST_ACQUIRE, 300, 300, 0, 0, "en_acquire");
    en = 1'b0;
    hit_c(0, 310, 300, ST_IDLE, CX, CX, 0, 0, "en_low_idle");
    hit_c(0, 310, 300, ST_IDLE, CX, CX, 0, 0, "en_low_hold");
    en = 1'b1;
  endtask

  task automatic test_acquire_timeout();
    hit_c(0, 400, 400, ST_ACQUIRE, 400, 400, 0, 0, "acq_entry");
    for (int i = 0; i < 7; i++) none_c(0, ST_ACQUIRE, 400, 400, 0, 0, "acq_wait");
    none_c(0, ST_COAST, 400, 400, 0, 0, "acq_timeout_coast");
    hit_c(0, 402, 401, ST_TRACKING, 402, 401, 0, 0, "coast_hit_tracking");
  endtask

  initial begin
    test_reset();
    test_lock_fire();
    test_coast();
    test_unstable();
    test_arm_drop();
    test_saturation();
    test_reset_firing();
    test_enable();
    test_acquire_timeout();
    @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
